// File: rtl/alu_8bit_seq.sv
// -----------------------------------------------------------------------------
// alu_8bit_seq
//   Multi-cycle ALU that answers one request at a time, with a valid/ready
//   handshake on each side. It uses the same 3-bit opcode map and 2*WIDTH-bit
//   result format as the combinational 8-bit ALU.
//   ADD, SUB, AND, OR, NEG and XOR complete in one cycle. Division by zero also
//   completes in one cycle. MUL runs as an iterative shift-add. DIV runs as a
//   restoring divider that produces one quotient bit per cycle, MSB first.
//
// Ports
//   clk        in   1        clock; all state updates on posedge
//   rst        in   1        synchronous active-high reset
//   in_valid   in   1        request valid
//   in_ready   out  1        request can be accepted (high only in IDLE)
//   a, b       in   WIDTH    unsigned operands
//   sel        in   3        000 ADD,001 SUB,010 MUL,011 DIV,100 AND,101 OR,
//                            110 NEG,111 XOR
//   out_valid  out  1        res/err valid
//   out_ready  in   1        consumer takes the result
//   res        out  2*WIDTH  result (DIV: {remainder, quotient})
//   err        out  1        DIV with b == 0
// -----------------------------------------------------------------------------
module alu_8bit_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] res,
  output logic               err
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_NEG = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [RW-1:0]    acc_q, acc_d;   // MUL: partial product; DIV: {rem, dividend/quotient}
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    res_q, res_d;
  logic             err_q, err_d;

  logic             accept;
  logic             last_iter;
  logic [RW-1:0]    simple_res;
  logic [WIDTH-1:0] neg_a;
  logic [RW-1:0]    mul_addend;
  logic [RW-1:0]    mul_acc;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] div_rem;
  logic [RW-1:0]    div_acc;

  assign accept    = in_valid && (state_q == S_IDLE);
  assign last_iter = (cnt_q == CW'(WIDTH - 1));
  assign neg_a     = ~a + 1'b1;

  // Single-cycle results. The RW-bit subtraction wraps, so a negative
  // difference comes out sign-extended.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    simple_res = '0;
    unique case (sel)
      OP_ADD:  simple_res = RW'(a) + RW'(b);
      OP_SUB:  simple_res = RW'(a) - RW'(b);
      OP_AND:  simple_res = RW'(a & b);
      OP_OR:   simple_res = RW'(a | b);
      OP_NEG:  simple_res = RW'(neg_a);
      OP_XOR:  simple_res = RW'(a ^ b);
      default: simple_res = '0;
    endcase
  end

  // Shift-add step: in iteration i, add b<<i when a[i] is set.
  assign mul_addend = RW'(b_q) << cnt_q;
  assign mul_acc    = a_q[cnt_q] ? (acc_q + mul_addend) : acc_q;

  // Restoring step: shift the next dividend bit into the remainder, and
  // subtract b when the result fits. After a successful subtract the
  // remainder is below b, so a WIDTH-bit difference is exact.
  assign div_shift = {acc_q[RW-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  assign div_diff  = div_shift[WIDTH-1:0] - b_q;
  assign div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
  assign div_acc   = {div_rem, acc_q[WIDTH-2:0], div_ge};

  // State and datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge, in any statement order.
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (sel == OP_MUL)                     state_d = S_MUL;
          else if (sel == OP_DIV && b != '0)     state_d = S_DIV;
          else                                   state_d = S_DONE;
        end
      end
      S_MUL, S_DIV: if (last_iter) state_d = S_DONE;
      S_DONE:       if (out_ready) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Datapath next-state. Operands are latched on accept. Later changes to
  // the inputs do not reach the running operation.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    res_d = res_q;
    err_d = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d   = a;
          b_d   = b;
          cnt_d = '0;
          err_d = 1'b0;
          acc_d = (sel == OP_DIV) ? RW'(a) : '0;
          if (sel == OP_DIV && b == '0) begin
            res_d = '1;
            err_d = 1'b1;
          end else if (sel != OP_MUL && sel != OP_DIV) begin
            res_d = simple_res;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_acc;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) res_d = mul_acc;
      end
      S_DIV: begin
        acc_d = div_acc;
        cnt_d = cnt_q + 1'b1;
        if (last_iter) res_d = div_acc;
      end
      default: ;
    endcase
  end

  // Outputs are decoded straight from registers.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    res       = res_q;
    err       = err_q;
  end

endmodule
